// File: rtl/sub4_seq.sv
// sub4_seq: sequential four-operand subtractor, Y = A - B - C - D.
// One subtraction per clock through a single shared (n+3)-bit datapath,
// valid/ready handshake on both the operand and the result side.
// Optional build macro SUB4_CLAMP_EN: clamp negative results to zero on Y
// (neg still reports the true sign).
module sub4_seq #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic [n-1:0] C,
  input  logic [n-1:0] D,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n+2:0] Y,
  output logic         neg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SUB_B = 3'd1,
    SUB_C = 3'd2,
    SUB_D = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t         state, state_nxt;
  logic [n+2:0]   acc;
  logic [n-1:0]   b_r, c_r, d_r;
  logic [n+2:0]   sub_op;
  logic [n+2:0]   diff;
  logic           accept;

  // Handshake: a new set can enter when idle, or when the held result leaves on this edge.
  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
    accept    = in_valid && in_ready;
  end

  // Shared datapath: pick the subtrahend for the current step, zero-extended.
  always_comb begin
    sub_op = '0;
    case (state)
      SUB_B:   sub_op = {3'b000, b_r};
      SUB_C:   sub_op = {3'b000, c_r};
      SUB_D:   sub_op = {3'b000, d_r};
      default: sub_op = '0;
    endcase
    diff = acc - sub_op;
  end

  // Next-state: fixed three-step walk, then hold in DONE until the consumer takes it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SUB_B;
      SUB_B:   state_nxt = SUB_C;
      SUB_C:   state_nxt = SUB_D;
      SUB_D:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? SUB_B : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, operand capture, accumulator steps and result load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      b_r   <= '0;
      c_r   <= '0;
      d_r   <= '0;
      Y     <= '0;
      neg   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc <= {3'b000, A};
        b_r <= B;
        c_r <= C;
        d_r <= D;
      end else if ((state == SUB_B) || (state == SUB_C) || (state == SUB_D)) begin
        acc <= diff;
      end
      if (state == SUB_D) begin
        neg <= diff[n+2];
`ifdef SUB4_CLAMP_EN
        Y   <= diff[n+2] ? '0 : diff;
`else
        Y   <= diff;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sub4_seq.sv
// Scoreboard bench for sub4_seq: driver pushes expected results on accept,
// monitor pops and compares on each result handshake.
module tb_sub4_seq;
  localparam int N = 4;
  localparam int W = N + 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] A = '0, B = '0, C = '0, D = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] Y;
  logic         neg;

  sub4_seq #(.n(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .C(C), .D(D),
    .out_valid(out_valid), .out_ready(out_ready), .Y(Y), .neg(neg)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] y; logic ng; int cyc; } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cycle = 0;
  bit acc_hit;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(string nm, longint act, longint ex);
    total++;
    if (act != ex) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, act, ex, cycle);
    end
  endtask

  task automatic fail(string nm);
    total++;
    bad++;
    $display("FAIL %s got=none want=event (cycle %0d)", nm, cycle);
  endtask

  // Reference: plain integer arithmetic, wrapped to W bits.
  function automatic exp_t model(int ta, int tb, int tc, int td);
    exp_t e;
    int   dv;
    dv   = ta - tb - tc - td;
    e.ng = (dv < 0);
    e.y  = dv[W-1:0];
`ifdef SUB4_CLAMP_EN
    if (dv < 0) e.y = '0;
`endif
    e.cyc = cycle;
    return e;
  endfunction

  // One clock: detect the transfer ahead of the edge, then step past it.
  task automatic cyc();
    @(negedge clk);
    acc_hit = 0;
    if (rst_n && in_valid && in_ready) begin
      q.push_back(model(int'(A), int'(B), int'(C), int'(D)));
      acc_hit = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  task automatic send(int ta, int tb, int tc, int td);
    A = N'(ta); B = N'(tb); C = N'(tc); D = N'(td);
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (acc_hit) break;
    end
    if (!acc_hit) fail("send_timeout");
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    q.delete();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", Y, 0);
    chk("rst_neg", neg, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: latency, handshake rules, stall stability and result values.
  logic         prev_v = 0, stall = 0, sn = 0;
  logic [W-1:0] sy = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 0;
      stall  = 0;
    end else begin
      if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_y", Y, sy);
        chk("stall_neg", neg, sn);
      end
      if (out_valid && !prev_v) begin
        if (q.size() == 0) fail("stale_result");
        else chk("latency", cycle, q[0].cyc + 4);
      end
      if (out_valid) chk("in_ready_done", in_ready, out_ready);
      else if (q.size() != 0 && q[q.size()-1].cyc < cycle) chk("in_ready_busy", in_ready, 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) fail("unexpected_result");
        else begin
          exp_t e;
          e = q.pop_front();
          chk("result_y", Y, e.y);
          chk("result_neg", neg, e.ng);
        end
      end
      stall  = out_valid && !out_ready;
      sy     = Y;
      sn     = neg;
      prev_v = out_valid;
    end
  end

  initial begin
    idle(2);
    do_reset();

    // Directed values, including both range extremes.
    out_ready = 1'b1;
    send(5, 2, 12, 15);   idle(6);
    send(15, 0, 0, 0);    idle(6);
    send(0, 15, 15, 15);  idle(6);

    // Backpressure: hold the result for 5 cycles with a new set waiting.
    out_ready = 1'b0;
    send(9, 1, 2, 3);
    idle(3);
    A = 4'd3; B = 4'd7; C = 4'd1; D = 4'd0;
    in_valid = 1'b1;
    idle(5);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    out_ready = 1'b1;
    cyc();
    chk("bp_same_edge_accept", acc_hit, 1);
    in_valid = 1'b0;
    idle(6);

    // Back-to-back with changing operands after each accept.
    send(12, 3, 4, 1);
    A = 4'd7; B = 4'd8; C = 4'd0; D = 4'd2;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 10; k++) begin
        cyc();
        if (acc_hit) break;
      end
      if (!acc_hit) fail("b2b_timeout");
      A = 4'd1; B = 4'd0; C = 4'd11; D = 4'd6;
    end
    in_valid = 1'b0;
    idle(6);

    // Reset while in SUB_C: nothing may emerge afterwards.
    send(14, 1, 1, 1);
    cyc();
    do_reset();
    idle(8);

    // in_valid during the busy steps must be ignored.
    send(10, 4, 3, 2);
    A = 4'd0; B = 4'd15; C = 4'd15; D = 4'd15;
    in_valid = 1'b1;
    idle(3);
    in_valid = 1'b0;
    idle(6);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      A = N'($urandom); B = N'($urandom); C = N'($urandom); D = N'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) cyc();
    chk("drain_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sub4_seq.md
Name: sub4_seq

Overview:
Sequential four-operand subtractor computing Y = A - B - C - D, the inverse-direction counterpart of the team's four-operand adder.
- One subtraction per clock through a single shared (n+3)-bit subtract datapath.
- valid/ready handshake on both the operand side and the result side.
- Sits between an operand source and a result consumer in the arithmetic chapter datapaths.

Parameters:
n, 4, operand width in bits (n >= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  operand set A..D valid
in_ready  output  1  block can accept an operand set this cycle
A  input  n  minuend, unsigned
B  input  n  subtrahend 1, unsigned
C  input  n  subtrahend 2, unsigned
D  input  n  subtrahend 3, unsigned
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
Y  output  n+3  result, two's complement signed
neg  output  1  Y < 0 (true difference, before optional clamp)

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous, active-low.
- Reset: sampled at a clk edge with rst_n=0, regardless of state. After that edge:
  - state=IDLE, accumulator=0, B/C/D registers=0.
  - out_valid=0, Y=0, neg=0, in_ready=1.
  - An in-flight operation is discarded and no result is produced.
- States: IDLE, SUB_B, SUB_C, SUB_D, DONE.
- Accept: a transfer occurs on an edge where in_valid && in_ready.
  - acc <= zero-extend(A) to n+3 bits.
  - B, C, D captured into registers.
  - state -> SUB_B.
  - Inputs A..D are don't-care after the accept edge.
- SUB_B: acc <= acc - B, -> SUB_C.
- SUB_C: acc <= acc - C, -> SUB_D.
- SUB_D: acc <= acc - D, -> DONE; the result registers Y and neg are loaded on this edge.
- DONE: out_valid=1. Y and neg are held stable until the edge where out_valid && out_ready.
- On that result-handshake edge:
  - if in_valid=1, the new operand set is accepted (-> SUB_B);
  - otherwise -> IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational from state and out_ready only.
- in_ready=0 in SUB_B/SUB_C/SUB_D. in_valid during those states is ignored, not queued.
- Latency: out_valid rises 4 edges after the accept edge (accept edge counts as edge 1). Max throughput 1 result per 4 cycles with out_ready held 1.
- Arithmetic: all subtraction is in n+3-bit two's complement.
  - Range is -3*(2^n-1) .. 2^n-1, so no overflow is possible.
  - neg = acc[n+2] after the SUB_D step.
- Boundaries:
  - A=0 with B=C=D=max gives the most negative result.
  - A=max with B=C=D=0 gives the max positive result.
  - out_ready=0 indefinitely: block stalls in DONE, output stable, in_ready=0.

Optional Feature:
SUB4_CLAMP_EN
- Defined: on the SUB_D edge, if the true result is negative, Y is loaded with 0; otherwise with the difference. neg still reflects the true sign.
- Not defined: Y is the full signed difference.
- Handshake and timing are identical in both builds.

Test Plan:
- n=4, reset then A=5,B=2,C=12,D=15, out_ready=1 -> out_valid 4 edges after accept, Y=7'h68 (-24), neg=1 (with SUB4_CLAMP_EN: Y=0, neg=1).
- A=15,B=C=D=0 -> Y=7'd15, neg=0. Then A=0,B=C=D=15 -> Y=7'h53 (-45), neg=1.
- Backpressure: result ready, out_ready=0 for 5 cycles with in_valid=1 -> Y/neg/out_valid stable, in_ready=0. out_ready=1 -> handshake and new accept on the same edge.
- Back-to-back: in_valid=1, out_ready=1 for 3 operand sets -> results spaced exactly 4 cycles, values correct in order.
- Reset mid-op: rst_n=0 for one edge while in SUB_C -> next cycle out_valid=0, Y=0, in_ready=1; no stale result emerges later.
- in_valid pulses during SUB_B..SUB_D with differing A..D -> ignored; result matches the originally accepted set.
